// File: rtl/rs232_pkg.sv
// Shared RS-232 constants and helpers for the receive and transmit sides.
// Bit timing is derived from the clock and baud rate; the FSM encoding is common.
package rs232_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rs232_state_t;

   // Clock cycles per bit, rounded to the nearest integer.
   function automatic int unsigned unit_cycles(input int unsigned clock_freq,
                                               input int unsigned baud_rate);
      return (clock_freq + baud_rate / 2) / baud_rate;
   endfunction

   function automatic int unsigned half_cycles(input int unsigned unit);
      return unit / 2;
   endfunction

   localparam int unsigned UNIT = unit_cycles(133000000, 115200);
   localparam int unsigned HALF = half_cycles(UNIT);

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rs232_recv_fifo_if.sv
// Byte stream from the receiver to its consumer: data/valid offered, ready accepts.
interface rs232_recv_fifo_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/rs232_recv_fifo_byte_fifo.sv
// Small byte FIFO with occupancy count; pointers wrap modulo DEPTH.
module byte_fifo #(
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             push,
   input  logic [7:0]       push_data,
   output logic             full,
   input  logic             pop,
   output logic             empty,
   output logic [7:0]       head,
   output logic [CNT_W-1:0] count
);

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             pop_ok;
   logic             push_ok;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign count   = count_reg;

   // Head is read combinationally so it is presentable the cycle count leaves zero.
   assign head = mem[rd_ptr_reg];

   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
         end
         count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

endmodule

// File: rtl/rs232_recv_fifo.sv
// RS-232 8N1 receiver with majority-vote sampling feeding a byte FIFO.
// Hardware flow control via ctsn_pin keeps one slot spare for a byte in flight.
module rs232_recv_fifo
   import rs232_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 133000000,
   parameter int unsigned BAUD_RATE  = 115200,
   parameter int          DEPTH      = 4
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              txd_pin,
   output logic              ctsn_pin,
   output logic              frame_error,
   output logic              overrun,
   rs232_recv_fifo_if.master rx_bus
);

   localparam int unsigned BIT_CYCLES = unit_cycles(CLOCK_FREQ, BAUD_RATE);
   localparam int unsigned MID_CYCLES = half_cycles(BIT_CYCLES);
   localparam int          TIMER_W    = $clog2(BIT_CYCLES + 1);
   localparam int          CNT_W      = $clog2(DEPTH + 1);

   logic [1:0]         sync_reg;
   logic [1:0]         hist_reg;
   logic               rx;
   logic               sample;
   rs232_state_t       state_reg, state_next;
   logic [TIMER_W-1:0] timer_reg, timer_next;
   logic [2:0]         bit_cnt_reg, bit_cnt_next;
   logic [7:0]         shift_reg, shift_next;
   logic               push;
   logic               bad_stop;
   logic               pop;
   logic               push_acc;
   logic               full;
   logic               empty;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_next;
   logic               ctsn_reg;
   logic               frame_error_reg;
   logic               overrun_reg;

   assign rx     = sync_reg[1];
   // Majority over the line as seen one cycle ago, two cycles ago and now.
   assign sample = majority3(hist_reg[1], hist_reg[0], rx);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_reg    <= 2'b11;
         hist_reg    <= 2'b11;
         state_reg   <= IDLE;
         timer_reg   <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
      end else begin
         sync_reg    <= {sync_reg[0], txd_pin};
         hist_reg    <= {hist_reg[0], rx};
         state_reg   <= state_next;
         timer_reg   <= timer_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
      end
   end

   // Vote completes one cycle after the centre sample, so bit timers restart at 1
   // to keep later windows centred and the count within UNIT.
   always_comb begin
      state_next   = state_reg;
      timer_next   = timer_reg + 1'b1;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      push         = 1'b0;
      bad_stop     = 1'b0;
      case (state_reg)
         IDLE: begin
            timer_next = '0;
            if (!rx) begin
               state_next = START;
            end
         end
         START: begin
            if (timer_reg == TIMER_W'(MID_CYCLES + 1)) begin
               if (sample) begin
                  state_next = IDLE;
               end else begin
                  state_next   = DATA;
                  timer_next   = TIMER_W'(1);
                  bit_cnt_next = '0;
               end
            end
         end
         DATA: begin
            if (timer_reg == TIMER_W'(BIT_CYCLES)) begin
               shift_next   = {sample, shift_reg[7:1]};
               timer_next   = TIMER_W'(1);
               bit_cnt_next = bit_cnt_reg + 1'b1;
               if (bit_cnt_reg == 3'd7) begin
                  state_next = STOP;
               end
            end
         end
         STOP: begin
            if (timer_reg == TIMER_W'(BIT_CYCLES)) begin
               state_next = IDLE;
               push       = sample;
               bad_stop   = !sample;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign pop        = rx_bus.valid && rx_bus.ready;
   assign push_acc   = push && (!full || pop);
   assign count_next = count + CNT_W'(push_acc) - CNT_W'(pop);

   byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .resetn    (resetn),
      .push      (push),
      .push_data (shift_reg),
      .full      (full),
      .pop       (pop),
      .empty     (empty),
      .head      (rx_bus.data),
      .count     (count)
   );

   assign rx_bus.valid = !empty;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ctsn_reg        <= 1'b1;
         frame_error_reg <= 1'b0;
         overrun_reg     <= 1'b0;
      end else begin
         ctsn_reg        <= (count_next >= CNT_W'(DEPTH - 1));
         frame_error_reg <= bad_stop;
         overrun_reg     <= push && full && !pop;
      end
   end

   assign ctsn_pin    = ctsn_reg;
   assign frame_error = frame_error_reg;
   assign overrun     = overrun_reg;

endmodule

// File: doc/rs232_recv_fifo.md
RS232_RECV_FIFO -- requirements
Module: rs232_recv_fifo

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CLOCK_FREQ, 133000000, clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- DEPTH, 4, FIFO entries; minimum 2.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clock, input, 1, single clock.
- resetn, input, 1, asynchronous active-low reset.
- txd_pin, input, 1, asynchronous serial line; idles high.
- ctsn_pin, output, 1, clear-to-send, active low; 1 means the host must stop sending.
- data, output, 8, head-of-FIFO byte.
- valid, output, 1, data holds an unread byte.
- ready, input, 1, consumer accepts data this cycle.
- frame_error, output, 1, one-cycle pulse when a bad stop bit is sampled.
- overrun, output, 1, one-cycle pulse when a good byte is dropped because the FIFO is full.

REQ-003 The block SHALL use one clock, `clock`; reset SHALL be asynchronous and active-low on `resetn`.

Function
REQ-004 The block SHALL pass txd_pin through a 2-flop synchronizer that resets to 1; all logic SHALL use the synchronized value.

REQ-005 UNIT SHALL be CLOCK_FREQ/BAUD_RATE rounded to the nearest integer; HALF SHALL be UNIT/2 rounded down; the timer width SHALL be $clog2(UNIT+1).

REQ-006 Each bit sample SHALL be the 2-of-3 majority of the synchronized line at timer values T-1, T and T+1.

REQ-007 The receive FSM SHALL have four states: IDLE, START, DATA, STOP.

REQ-008 IDLE -> START SHALL occur on the first cycle the synchronized line is 0; the timer SHALL clear at that point.

REQ-009 In START, the sample SHALL be taken at T=HALF.
- Majority 1 (glitch): return to IDLE with no output.
- Majority 0: enter DATA and restart the timer.

REQ-010 In DATA, bits SHALL be sampled every UNIT cycles, LSB first, into a shift register; after the 8th bit the FSM SHALL enter STOP.

REQ-011 In STOP, the sample SHALL be taken at T=UNIT and the FSM SHALL return to IDLE on the next cycle, without waiting for the end of the stop bit.

REQ-012 If the stop sample is 0, frame_error SHALL pulse for 1 cycle and the byte SHALL be discarded.

REQ-013 If the stop sample is 1, the byte SHALL be pushed into the FIFO, and valid SHALL assert on the following cycle when the FIFO was empty.

REQ-014 A push SHALL be accepted when count<DEPTH, or when a pop occurs in the same cycle. Otherwise overrun SHALL pulse for 1 cycle and the byte SHALL be dropped.

REQ-015 A pop SHALL occur when valid && ready.
- Simultaneous push and pop SHALL leave count unchanged.
- Read and write pointers SHALL wrap modulo DEPTH.

REQ-016 valid SHALL equal (count!=0); data SHALL show the head entry and stay stable while valid && !ready.

REQ-017 ctsn_pin SHALL be registered and SHALL equal (count >= DEPTH-1), which reserves one slot for an in-flight byte.

Reset
REQ-018 While resetn=0, the outputs and state SHALL be:
- FSM in IDLE; timer, count and pointers 0.
- Synchronizer flops 1.
- ctsn_pin=1, valid=0, frame_error=0, overrun=0.
- data don't-care.

REQ-019 Reset asserted mid-frame or with a non-empty FIFO SHALL discard all partial and stored bytes.

REQ-020 After reset release, ctsn_pin SHALL fall within 1 cycle.

Structure
REQ-021 Constants UNIT, HALF and the FSM state encodings SHALL live in shared package rs232_pkg, which the transmit side also uses.

REQ-022 The FIFO SHALL be a separate sub-module, byte_fifo (DEPTH parameter; push/full/pop/empty, plus count output). The FSM and sampler SHALL remain in rs232_recv_fifo.

Verification
All scenarios use CLOCK_FREQ=16000000, BAUD_RATE=1000000 (UNIT=16) and DEPTH=4.

REQ-023 Send 0xA5 with a good stop bit and ready=1 -> data=0xA5 with valid high for exactly 1 cycle; frame_error=0 and overrun=0.

REQ-024 Drive an 8-cycle low glitch while idle -> no valid, no frame_error, FSM back in IDLE before T=HALF+2.

REQ-025 Send 0x3C with stop bit forced low -> frame_error pulses once; valid stays 0.

REQ-026 With ready=0, send 0x01..0x05 back to back -> ctsn_pin=1 after the 3rd byte; 5th byte raises overrun; then with ready=1, reads return 0x01,0x02,0x03,0x04 in order.

REQ-027 With the FIFO full and ready=1 at the cycle of the 5th stop sample -> no overrun; count stays 4; byte 0x05 is read last.

REQ-028 Assert resetn=0 mid-DATA with 2 bytes stored -> valid=0 and ctsn_pin=1 immediately; after release, the next good frame 0x5A is the only byte delivered.
